bram_access_arbiter: RTL and testbench

- Shares one simple dual-port block memory between two requesters (A = index 0, B = index 1). The memory has separate read and write ports, a 1-cycle registered read and no write enable.
- Each requester uses a valid/ready request channel and receives a read-response strobe.
- Every cycle the memory writes something. On cycles with no granted write, the block parks the write port on a reserved address, so idle cycles never corrupt user data.

---
 rtl/bram_arb_pkg.sv | 16 +
 rtl/rr_arb2.sv | 40 ++++
 rtl/bram_access_arbiter.sv | 99 +++++++++
 tb/tb_bram_access_arbiter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/bram_arb_pkg.sv
// Shared types for the block-memory access arbiter.
package bram_arb_pkg;

    typedef logic [0:0] req_id_t;

    localparam req_id_t REQ_A = 1'b0;
    localparam req_id_t REQ_B = 1'b1;

    // Read-response tag carried one cycle alongside the registered memory read.
    typedef struct packed {
        logic    valid;
        req_id_t id;
        logic    err;
    } rsp_tag_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter. The pointer names the requester that wins
// contention. After any grant, the pointer moves to the requester that was
// not granted.
module rr_arb2
    import bram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] grant,
    output req_id_t    grant_id
);

    req_id_t ptr;

    // Pick the winner; nothing is granted while reset is held.
    always_comb begin
        grant    = '0;
        grant_id = REQ_A;
        if (!reset) begin
            if (req == 2'b11)
                grant_id = ptr;
            else if (req[1])
                grant_id = REQ_B;
            else
                grant_id = REQ_A;
            if (|req)
                grant = 2'b01 << grant_id;
        end
    end

    // Pointer always moves away from the requester just served.
    always_ff @(posedge clk) begin
        if (reset)
            ptr <= REQ_A;
        else if (|req)
            ptr <= ~grant_id;
    end

endmodule

// File: rtl/bram_access_arbiter.sv
// Shares a simple dual-port block memory (1-cycle registered read,
// write every cycle) between two valid/ready requesters. Reads and writes
// are arbitrated independently. Idle write cycles are parked on PARK_ADDR.
module bram_access_arbiter
    import bram_arb_pkg::*;
#(
    parameter int unsigned            ADDR_W    = 7,
    parameter int unsigned            DATA_W    = 1,
    parameter logic [ADDR_W-1:0]      PARK_ADDR = '1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [1:0]             req_valid,
    input  logic [1:0]             req_we,
    input  logic [1:0][ADDR_W-1:0] req_addr,
    input  logic [1:0][DATA_W-1:0] req_wdata,
    output logic [1:0]             req_ready,
    output logic [1:0]             rsp_valid,
    output logic [DATA_W-1:0]      rsp_rdata,
    output logic [1:0]             err,
    output logic [ADDR_W-1:0]      mem_raddr,
    output logic [ADDR_W-1:0]      mem_waddr,
    output logic [DATA_W-1:0]      mem_din,
    input  logic [DATA_W-1:0]      mem_dout
);

    logic [1:0] rd_req, wr_req, rd_gnt, wr_gnt;
    req_id_t    rd_id, wr_id;
    logic       rd_any, wr_any;
    rsp_tag_t   rd_tag;
    logic [1:0] wr_err;

    assign rd_req = req_valid & ~req_we;
    assign wr_req = req_valid & req_we;

    rr_arb2 u_rd_arb (
        .clk      (clk),
        .reset    (reset),
        .req      (rd_req),
        .grant    (rd_gnt),
        .grant_id (rd_id)
    );

    rr_arb2 u_wr_arb (
        .clk      (clk),
        .reset    (reset),
        .req      (wr_req),
        .grant    (wr_gnt),
        .grant_id (wr_id)
    );

    assign rd_any = |rd_gnt;
    assign wr_any = |wr_gnt;

    // Drive memory ports from the grants; park both ports when idle or in reset.
    always_comb begin
        req_ready = rd_gnt | wr_gnt;
        mem_raddr = PARK_ADDR;
        mem_waddr = PARK_ADDR;
        mem_din   = '0;
        if (rd_any)
            mem_raddr = req_addr[rd_id];
        if (wr_any) begin
            mem_waddr = req_addr[wr_id];
            mem_din   = req_wdata[wr_id];
        end
    end

    // Tag the read for the cycle its data returns; record write errors.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_tag <= '0;
            wr_err <= '0;
        end else begin
            rd_tag.valid <= rd_any;
            rd_tag.id    <= rd_id;
            rd_tag.err   <= rd_any && (req_addr[rd_id] == PARK_ADDR);
            wr_err       <= (wr_any && (req_addr[wr_id] == PARK_ADDR)) ? wr_gnt : 2'b00;
        end
    end

    // Route the response. Gating with reset means a read granted just before
    // reset rises never reaches the requester.
    always_comb begin
        rsp_valid = '0;
        rsp_rdata = '0;
        err       = '0;
        if (!reset) begin
            err = wr_err;
            if (rd_tag.valid) begin
                rsp_valid[rd_tag.id] = 1'b1;
                err[rd_tag.id]       = err[rd_tag.id] | rd_tag.err;
                if (!rd_tag.err)
                    rsp_rdata = mem_dout;
            end
        end
    end

endmodule

// File: tb/tb_bram_access_arbiter.sv
// Self-checking bench for bram_access_arbiter with an attached behavioural
// block memory and a reference model of the arbitration rules.
module tb_bram_access_arbiter;

    localparam int unsigned ADDR_W = 7;
    localparam int unsigned DATA_W = 1;
    localparam logic [6:0]  PARK   = 7'd127;

    logic             clk = 1'b0;
    logic             reset;
    logic [1:0]       req_valid, req_we, req_ready, rsp_valid, err;
    logic [1:0][6:0]  req_addr;
    logic [1:0][0:0]  req_wdata;
    logic [0:0]       rsp_rdata, mem_din, mem_dout;
    logic [6:0]       mem_raddr, mem_waddr;

    int checks   = 0;
    int failures = 0;

    // Memory attached to the DUT and the model's own copy of its contents.
    logic mem     [0:127];
    logic ref_mem [0:127];

    // Model state: expected response for the next cycle and arbitration pointers.
    logic [1:0] pend_v   = 2'b00;
    logic [1:0] pend_err = 2'b00;
    logic       pend_rdata = 1'b0;
    int         ptr_rd = 0;
    int         ptr_wr = 0;

    bram_access_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .PARK_ADDR(PARK)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .err       (err),
        .mem_raddr (mem_raddr),
        .mem_waddr (mem_waddr),
        .mem_din   (mem_din),
        .mem_dout  (mem_dout)
    );

    always #5 clk = ~clk;

    // Read-first simple dual-port memory, registered read.
    always @(posedge clk) begin
        mem_dout       <= mem[mem_raddr];
        mem[mem_waddr] <= mem_din;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Round-robin rule: on contention the pointer wins, otherwise the sole requester.
    function automatic int pick(input logic [1:0] r, input int p);
        if (r == 2'b11) return p;
        if (r[1])       return 1;
        return 0;
    endfunction

    task automatic step(input logic rst, input logic [1:0] v, input logic [1:0] we,
                        input logic [6:0] a0, input logic [6:0] a1,
                        input logic d0, input logic d1, output logic [1:0] acc);
        logic [1:0] rq, wq, exp_ready, exp_rv, exp_err;
        logic [6:0] exp_raddr, exp_waddr;
        logic       exp_din;
        int         rw, ww;
        @(negedge clk);
        reset        = rst;
        req_valid    = v;
        req_we       = we;
        req_addr[0]  = a0;
        req_addr[1]  = a1;
        req_wdata[0] = d0;
        req_wdata[1] = d1;
        #1;
        rq = rst ? 2'b00 : (v & ~we);
        wq = rst ? 2'b00 : (v & we);
        rw = pick(rq, ptr_rd);
        ww = pick(wq, ptr_wr);
        exp_ready = 2'b00;
        exp_raddr = PARK;
        exp_waddr = PARK;
        exp_din   = 1'b0;
        if (rq != 2'b00) begin
            exp_ready[rw] = 1'b1;
            exp_raddr     = (rw == 1) ? a1 : a0;
        end
        if (wq != 2'b00) begin
            exp_ready[ww] = 1'b1;
            exp_waddr     = (ww == 1) ? a1 : a0;
            exp_din       = (ww == 1) ? d1 : d0;
        end
        exp_rv  = rst ? 2'b00 : pend_v;
        exp_err = rst ? 2'b00 : pend_err;

        check("req_ready", 32'(req_ready), 32'(exp_ready));
        check("mem_raddr", 32'(mem_raddr), 32'(exp_raddr));
        check("mem_waddr", 32'(mem_waddr), 32'(exp_waddr));
        check("mem_din",   32'(mem_din),   32'(exp_din));
        check("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
        check("err",       32'(err),       32'(exp_err));
        if (exp_rv != 2'b00)
            check("rsp_rdata", 32'(rsp_rdata), 32'(pend_rdata));

        pend_v   = 2'b00;
        pend_err = 2'b00;
        if (rq != 2'b00) begin
            pend_v[rw] = 1'b1;
            pend_rdata = (exp_raddr == PARK) ? 1'b0 : ref_mem[exp_raddr];
            if (exp_raddr == PARK) pend_err[rw] = 1'b1;
            ptr_rd = 1 - rw;
        end
        if (wq != 2'b00) begin
            if (exp_waddr == PARK) pend_err[ww] = 1'b1;
            else ref_mem[exp_waddr] = exp_din;
            ptr_wr = 1 - ww;
        end
        if (rst) begin
            ptr_rd = 0;
            ptr_wr = 0;
        end
        acc = exp_ready;
    endtask

    initial begin
        logic [1:0] acc;
        logic [1:0] hv, hwe, hd;
        logic [1:0][6:0] ha;

        for (int unsigned i = 0; i < 128; i++) begin
            mem[i]     = 1'($urandom_range(0, 1));
            ref_mem[i] = mem[i];
        end
        mem[5] = 1'b1;  ref_mem[5]  = 1'b1;
        mem[10] = 1'b1; ref_mem[10] = 1'b1;

        reset = 1'b1; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;

        // Reset state.
        step(1, 2'b00, 2'b00, 0, 0, 0, 0, acc);
        step(1, 2'b00, 2'b00, 0, 0, 0, 0, acc);

        // A reads address 5.
        step(0, 2'b01, 2'b00, 5, 0, 0, 0, acc);
        check("a_read5_ready", 32'(acc), 32'd1);
        step(0, 2'b00, 2'b00, 0, 0, 0, 0, acc);

        // A writes 0 to 10 while B reads 10 (old value), then B re-reads.
        step(0, 2'b11, 2'b01, 10, 10, 0, 0, acc);
        step(0, 2'b10, 2'b00, 0, 10, 0, 0, acc);
        step(0, 2'b00, 2'b00, 0, 0, 0, 0, acc);

        // Both read continuously.
        for (int unsigned i = 0; i < 6; i++)
            step(0, 2'b11, 2'b00, 7'(i), 7'(40 + i), 0, 0, acc);
        step(0, 2'b00, 2'b00, 0, 0, 0, 0, acc);

        // Idle period, then sweep every user address.
        for (int unsigned i = 0; i < 20; i++)
            step(0, 2'b00, 2'b00, 0, 0, 0, 0, acc);
        for (int unsigned a = 0; a < 127; a++)
            step(0, 2'b01, 2'b00, 7'(a), 0, 0, 0, acc);
        step(0, 2'b00, 2'b00, 0, 0, 0, 0, acc);

        // B targets the park address: read then write.
        step(0, 2'b10, 2'b00, 0, PARK, 0, 0, acc);
        step(0, 2'b10, 2'b10, 0, PARK, 0, 1, acc);
        step(0, 2'b00, 2'b00, 0, 0, 0, 0, acc);
        step(0, 2'b00, 2'b00, 0, 0, 0, 0, acc);

        // Read granted just before reset rises never responds.
        step(0, 2'b01, 2'b00, 3, 0, 0, 0, acc);
        step(1, 2'b00, 2'b00, 0, 0, 0, 0, acc);
        step(1, 2'b00, 2'b00, 0, 0, 0, 0, acc);
        step(0, 2'b11, 2'b00, 20, 30, 0, 0, acc);
        check("post_reset_a_wins", 32'(acc), 32'd1);
        step(0, 2'b10, 2'b00, 0, 30, 0, 0, acc);
        step(0, 2'b00, 2'b00, 0, 0, 0, 0, acc);

        // Randomized traffic; each requester holds its request until accepted.
        hv = 2'b00; hwe = 2'b00; ha = '0; hd = 2'b00;
        for (int unsigned n = 0; n < 400; n++) begin
            for (int unsigned r = 0; r < 2; r++) begin
                if (!hv[r] && ($urandom_range(0, 3) != 0)) begin
                    hv[r]  = 1'b1;
                    hwe[r] = 1'($urandom_range(0, 1));
                    ha[r]  = ($urandom_range(0, 15) == 0) ? PARK : 7'($urandom_range(0, 126));
                    hd[r]  = 1'($urandom_range(0, 1));
                end
            end
            step(($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0, hv, hwe, ha[0], ha[1], hd[0], hd[1], acc);
            hv = hv & ~acc;
        end
        step(0, 2'b00, 2'b00, 0, 0, 0, 0, acc);

        // Final readback: memory contents, including persistence across resets.
        for (int unsigned a = 0; a < 127; a++)
            step(0, 2'b10, 2'b00, 0, 7'(a), 0, 0, acc);
        step(0, 2'b00, 2'b00, 0, 0, 0, 0, acc);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
